// File: rtl/codec_cfg_pkg.sv
// Shared constants for the WM8731 power-up writer: device address, the
// register table sent after start, and the sequencer state encoding.
package codec_cfg_pkg;

  localparam logic [7:0] WM8731_ADDR = 8'h34;
  localparam int         NUM_CFG     = 11;

  localparam logic [15:0] CFG_TABLE [0:NUM_CFG-1] = '{
    16'h1E00, 16'h0097, 16'h0297, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_GAP,
    ST_FINISH
  } state_t;

  // Byte idx of a word frame: 0 = device address, 1 = {reg, data[8]}, 2 = data[7:0].
  function automatic logic [7:0] cfg_byte(input logic [3:0] word, input logic [1:0] idx);
    logic [15:0] w;
    w = (int'(word) < NUM_CFG) ? CFG_TABLE[word] : 16'h0000;
    case (idx)
      2'd0:    cfg_byte = WM8731_ADDR;
      2'd1:    cfg_byte = w[15:8];
      default: cfg_byte = w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit strobe: one-cycle tick every CLK_DIV cycles while enabled;
// the counter reloads whenever disabled so the first tick is a full period away.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int              CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (!i_en || r_cnt == '0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/i2c_codec_init.sv
// WM8731 power-up configuration master: writes CFG_TABLE over a write-only
// I2C bus, retrying NACKed words, and reports done or ack_err.
module i2c_codec_init
  import codec_cfg_pkg::*;
#(
  parameter int CLK_DIV   = 250,
  parameter int MAX_RETRY = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  output logic   I2C_SCLK,
  output logic   sda_oe,
  input  logic   sda_in,
  output logic   busy,
  output logic   done,
  output logic   ack_err,
  output state_t dbg_state
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t        r_state, n_state;
  logic [1:0]    r_q, n_q;
  logic [3:0]    r_bit, n_bit;
  logic [1:0]    r_byte, n_byte;
  logic [3:0]    r_word, n_word;
  logic [RW-1:0] r_retry, n_retry;
  logic          r_nack, n_nack;
  logic          r_err, n_err;
  logic          r_sclk, n_sclk;
  logic          r_oe, n_oe;
  logic          r_busy, n_busy;
  logic          r_done, n_done;
  logic          r_ack_err, n_ack_err;
  logic [7:0]    w_byte;
  logic          w_tick;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (r_busy),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_q       <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_word    <= '0;
      r_retry   <= '0;
      r_nack    <= 1'b0;
      r_err     <= 1'b0;
      r_sclk    <= 1'b1;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_state   <= n_state;
      r_q       <= n_q;
      r_bit     <= n_bit;
      r_byte    <= n_byte;
      r_word    <= n_word;
      r_retry   <= n_retry;
      r_nack    <= n_nack;
      r_err     <= n_err;
      r_sclk    <= n_sclk;
      r_oe      <= n_oe;
      r_busy    <= n_busy;
      r_done    <= n_done;
      r_ack_err <= n_ack_err;
    end
  end

  always_comb begin
    n_state   = r_state;
    n_q       = r_q;
    n_bit     = r_bit;
    n_byte    = r_byte;
    n_word    = r_word;
    n_retry   = r_retry;
    n_nack    = r_nack;
    n_err     = r_err;
    n_busy    = r_busy;
    n_done    = r_done;
    n_ack_err = r_ack_err;
    n_sclk    = 1'b1;
    n_oe      = 1'b0;
    w_byte    = 8'h00;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          n_state   = ST_START;
          n_q       = '0;
          n_bit     = '0;
          n_byte    = '0;
          n_word    = '0;
          n_retry   = '0;
          n_nack    = 1'b0;
          n_err     = 1'b0;
          n_busy    = 1'b1;
          n_done    = 1'b0;
          n_ack_err = 1'b0;
        end
      end
      ST_FINISH: begin
        n_state   = ST_IDLE;
        n_busy    = 1'b0;
        n_done    = !r_err;
        n_ack_err = r_err;
      end
      default: begin
        if (w_tick) begin
          // Every phase is four quarters; the 2-bit quarter count wraps into q0 of the next.
          n_q = r_q + 2'd1;
          case (r_state)
            ST_START: begin
              if (r_q == 2'd3) begin
                n_state = ST_BYTE;
                n_bit   = '0;
                n_byte  = '0;
              end
            end
            ST_BYTE: begin
              if (r_bit == 4'd8 && r_q == 2'd2) n_nack = sda_in;
              if (r_q == 2'd3) begin
                if (r_bit != 4'd8) begin
                  n_bit = r_bit + 4'd1;
                end else if (r_nack || r_byte == 2'd2) begin
                  n_state = ST_STOP;
                end else begin
                  n_bit  = '0;
                  n_byte = r_byte + 2'd1;
                end
              end
            end
            ST_STOP: begin
              if (r_q == 2'd3) n_state = ST_GAP;
            end
            ST_GAP: begin
              if (r_q == 2'd3) begin
                n_nack = 1'b0;
                if (r_nack) begin
                  if (r_retry == RW'(MAX_RETRY - 1)) begin
                    n_state = ST_FINISH;
                    n_err   = 1'b1;
                  end else begin
                    n_state = ST_START;
                    n_retry = r_retry + 1'b1;
                  end
                end else if (r_word == 4'(NUM_CFG - 1)) begin
                  n_state = ST_FINISH;
                end else begin
                  n_state = ST_START;
                  n_word  = r_word + 4'd1;
                  n_retry = '0;
                end
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    // Line levels are a registered decode of the phase being entered.
    w_byte = cfg_byte(n_word, n_byte);
    case (n_state)
      ST_START: n_oe = n_q[1];
      ST_BYTE: begin
        n_sclk = n_q[1];
        n_oe   = (n_bit != 4'd8) && !w_byte[3'd7 - n_bit[2:0]];
      end
      ST_STOP: begin
        n_sclk = n_q[1];
        n_oe   = (n_q != 2'd3);
      end
      default: ;
    endcase
  end

  assign I2C_SCLK  = r_sclk;
  assign sda_oe    = r_oe;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ack_err   = r_ack_err;
  assign dbg_state = r_state;

endmodule
